// File: rtl/id_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_fetch
// Purpose  : Decode-stage register file with write-to-read bypass, plus the
//            ID/EX operand latch with stall/flush control and stall-time
//            refresh of held operands.
// Revision : 1.0 - initial release
// ============================================================================
module id_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rs_addr,
    output logic [ADDR_W-1:0] ex_rt_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data
);

    localparam int c_nregs = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_nregs];

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_refresh_rs;
    logic              w_refresh_rt;

    logic              r_ex_valid;
    logic [ADDR_W-1:0] r_ex_rs_addr;
    logic [ADDR_W-1:0] r_ex_rt_addr;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;

    // Register 0 is never written, so it always reads back as zero.
    assign w_wr_en = wb_en && (wb_addr != '0);

    // Source operand reads: r0 forced to zero, same-cycle writeback bypassed.
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (rs_addr != '0) begin
            if (wb_en && (wb_addr == rs_addr)) w_rs_data = wb_data;
            else                               w_rs_data = r_regs[rs_addr];
        end
        if (rt_addr != '0) begin
            if (wb_en && (wb_addr == rt_addr)) w_rt_data = wb_data;
            else                               w_rt_data = r_regs[rt_addr];
        end
    end

    // A held operand is refreshed when its register is written during a stall.
    assign w_refresh_rs = w_wr_en && (wb_addr == r_ex_rs_addr);
    assign w_refresh_rt = w_wr_en && (wb_addr == r_ex_rt_addr);

    // Register array: cleared on reset, writeback only when not in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nregs; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // ID/EX latch: reset, then flush (beats stall), then stall with refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs_addr <= '0;
            r_ex_rt_addr <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
        end else if (flush) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs_addr <= '0;
            r_ex_rt_addr <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
        end else if (stall) begin
            if (w_refresh_rs) r_ex_rs_data <= wb_data;
            if (w_refresh_rt) r_ex_rt_data <= wb_data;
        end else begin
            r_ex_valid   <= id_valid;
            r_ex_rs_addr <= rs_addr;
            r_ex_rt_addr <= rt_addr;
            r_ex_rs_data <= w_rs_data;
            r_ex_rt_data <= w_rt_data;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_rs_addr = r_ex_rs_addr;
    assign ex_rt_addr = r_ex_rt_addr;
    assign ex_rs_data = r_ex_rs_data;
    assign ex_rt_data = r_ex_rt_data;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_operand_fetch
// Purpose  : Self-checking bench for id_operand_fetch: behavioural register
//            file and latch model feeding an expected-result queue, plus
//            directed checks of the documented scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_operand_fetch;

    localparam int c_dw = 32;
    localparam int c_aw = 5;

    typedef struct packed {
        logic            v;
        logic [c_aw-1:0] rsa;
        logic [c_aw-1:0] rta;
        logic [c_dw-1:0] rsd;
        logic [c_dw-1:0] rtd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_en;
    logic [c_aw-1:0] wb_addr;
    logic [c_dw-1:0] wb_data;
    logic            id_valid;
    logic [c_aw-1:0] rs_addr;
    logic [c_aw-1:0] rt_addr;
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [c_aw-1:0] ex_rs_addr;
    logic [c_aw-1:0] ex_rt_addr;
    logic [c_dw-1:0] ex_rs_data;
    logic [c_dw-1:0] ex_rt_data;

    int errors = 0;
    int checks = 0;

    logic [c_dw-1:0] m_regs [32];
    exp_t            m_ex;
    exp_t            q[$];

    id_operand_fetch #(.DATA_W(c_dw), .ADDR_W(c_aw)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .id_valid   (id_valid),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_rs_addr (ex_rs_addr),
        .ex_rt_addr (ex_rt_addr),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [c_dw-1:0] act,
                            input logic [c_dw-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [c_dw-1:0] model_read(input logic [c_aw-1:0] a);
        if (a == '0) return '0;
        if (wb_en && (wb_addr == a)) return wb_data;
        return m_regs[a];
    endfunction

    // One clock: predict the latch from the current inputs, advance, compare.
    task automatic cycle();
        exp_t e;
        exp_t got;
        e = m_ex;
        if (rst) begin
            e = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (flush) begin
                e = '0;
            end else if (stall) begin
                if (wb_en && wb_addr != '0 && wb_addr == m_ex.rsa) e.rsd = wb_data;
                if (wb_en && wb_addr != '0 && wb_addr == m_ex.rta) e.rtd = wb_data;
            end else begin
                e.v   = id_valid;
                e.rsa = rs_addr;
                e.rta = rt_addr;
                e.rsd = model_read(rs_addr);
                e.rtd = model_read(rt_addr);
            end
            if (wb_en && wb_addr != '0) m_regs[wb_addr] = wb_data;
        end
        m_ex = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            got = q.pop_front();
            check_eq("ex_valid",   {31'd0, ex_valid},   {31'd0, got.v});
            check_eq("ex_rs_addr", {27'd0, ex_rs_addr}, {27'd0, got.rsa});
            check_eq("ex_rt_addr", {27'd0, ex_rt_addr}, {27'd0, got.rta});
            check_eq("ex_rs_data", ex_rs_data, got.rsd);
            check_eq("ex_rt_data", ex_rt_data, got.rtd);
        end
    endtask

    task automatic idle_inputs();
        wb_en = 0; wb_addr = '0; wb_data = '0;
        id_valid = 0; rs_addr = '0; rt_addr = '0;
        stall = 0; flush = 0;
    endtask

    initial begin
        m_ex = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        idle_inputs();
        rst = 1;

        // Reset with a pending writeback to r5
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD;
        cycle(); cycle();
        check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("rst_rs_data", ex_rs_data, 32'd0);
        rst = 0; idle_inputs(); rs_addr = 5;
        cycle();
        check_eq("rst_r5_dropped", ex_rs_data, 32'd0);

        // Write r3, read back through the array two cycles later
        idle_inputs(); wb_en = 1; wb_addr = 3; wb_data = 32'h12345678;
        cycle();
        idle_inputs(); cycle();
        rs_addr = 3; cycle();
        check_eq("read_r3", ex_rs_data, 32'h12345678);

        // r0 write discarded
        idle_inputs(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        cycle();
        idle_inputs(); rt_addr = 0; id_valid = 1; cycle();
        check_eq("read_r0", ex_rt_data, 32'd0);

        // Same-cycle bypass to both ports
        idle_inputs(); wb_en = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5;
        rs_addr = 7; rt_addr = 7; id_valid = 1;
        cycle();
        check_eq("bypass_rs", ex_rs_data, 32'hA5A5A5A5);
        check_eq("bypass_rt", ex_rt_data, 32'hA5A5A5A5);

        // Stall refresh of a held operand
        idle_inputs(); wb_en = 1; wb_addr = 9; wb_data = 32'h1; cycle();
        idle_inputs(); rs_addr = 9; rt_addr = 3; id_valid = 1; cycle();
        check_eq("latch_r9_old", ex_rs_data, 32'h1);
        stall = 1; rs_addr = 2; rt_addr = 4; id_valid = 0; cycle();
        wb_en = 1; wb_addr = 9; wb_data = 32'h2; cycle();
        check_eq("stall_refresh", ex_rs_data, 32'h2);
        wb_en = 0; cycle();
        check_eq("stall_hold_addr", {27'd0, ex_rs_addr}, 32'd9);
        check_eq("stall_hold_rt", ex_rt_data, 32'h12345678);
        check_eq("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
        stall = 0; rs_addr = 9; id_valid = 1; cycle();
        check_eq("unstall_r9", ex_rs_data, 32'h2);

        // Flush beats stall; concurrent write still lands
        idle_inputs(); id_valid = 1; stall = 1; flush = 1; rs_addr = 3;
        wb_en = 1; wb_addr = 4; wb_data = 32'h55;
        cycle();
        check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("flush_rs_data", ex_rs_data, 32'd0);
        idle_inputs(); rs_addr = 4; id_valid = 1; cycle();
        check_eq("flush_write_r4", ex_rs_data, 32'h55);

        // Reset while stalled drops the in-flight write
        stall = 1; rst = 1; wb_en = 1; wb_addr = 6; wb_data = 32'h99;
        cycle();
        check_eq("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        idle_inputs(); rst = 0; rs_addr = 6; rt_addr = 4; id_valid = 1; cycle();
        check_eq("rst_stall_r6", ex_rs_data, 32'd0);
        check_eq("rst_stall_r4", ex_rt_data, 32'd0);

        // Randomised traffic on a small register window
        for (int n = 0; n < 300; n++) begin
            wb_en    = $urandom_range(0, 1) == 1;
            wb_addr  = c_aw'($urandom_range(0, 7));
            wb_data  = $urandom;
            id_valid = $urandom_range(0, 1) == 1;
            rs_addr  = c_aw'($urandom_range(0, 7));
            rt_addr  = c_aw'($urandom_range(0, 7));
            stall    = $urandom_range(0, 3) == 0;
            flush    = $urandom_range(0, 9) == 0;
            rst      = $urandom_range(0, 99) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_operand_fetch.md
# id_operand_fetch

Decode-stage register file and ID/EX operand latch for the pipelined MIPS core. Consumes the writeback port driven by the WB stage (`write_data_reg` plus its destination and enable) and serves two source operands (rs, rt) to EX. Operands are latched into ID/EX registers with stall/flush control. Same-cycle write-to-read bypass and stall-time refresh of held operands guarantee EX never sees a stale value.

## Interface
Parameters:
- DATA_W, 32, register and operand width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_en  in  1  writeback enable (RegWrite from WB)
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data (WB stage `write_data_reg`)
- id_valid  in  1  decode slot holds a real instruction
- rs_addr  in  ADDR_W  source register 1 index
- rt_addr  in  ADDR_W  source register 2 index
- stall  in  1  hold ID/EX latch contents
- flush  in  1  insert bubble into ID/EX
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_addr  out  ADDR_W  latched rs index
- ex_rt_addr  out  ADDR_W  latched rt index
- ex_rs_data  out  DATA_W  latched rs operand
- ex_rt_data  out  DATA_W  latched rt operand

## Operation
- Register array: 2^ADDR_W entries of DATA_W. Register 0 is hardwired zero: writes to it are discarded and reads return 0.
- Write: on the clock edge, if `wb_en` and `wb_addr != 0`, then `reg[wb_addr] <= wb_data`.
- Read, combinational, for each port p in {rs, rt}:
  - p_addr == 0: value is 0.
  - Else if `wb_en` and `wb_addr == p_addr`: value is `wb_data` (bypass).
  - Else: value is `reg[p_addr]`.
- ID/EX latch update, priority order:
  1. **rst**: all outputs cleared to 0, all registers cleared to 0.
  2. **flush**: `ex_valid` <= 0; `ex_*_addr` and `ex_*_data` <= 0. Flush wins over stall.
  3. **stall**: latch holds all fields, except a held operand is refreshed. If `wb_en`, `wb_addr != 0` and `wb_addr == ex_rs_addr`, then `ex_rs_data <= wb_data`. The same rule applies independently to rt.
  4. **Otherwise**: `ex_valid <= id_valid`; addresses and read values (with bypass) are latched. Operands are latched even when `id_valid` is 0.
- The register write always occurs while the latch is stalled or flushed; only rst suppresses it.
- Reset mid-operation: in-flight writeback on the rst cycle is dropped.

## Timing
- Reset value of every output: 0. After rst deasserts, all registers read 0.
- Latency: addresses presented in cycle N appear on `ex_*` after edge N+1; one cycle.
- Write visibility:
  - Same cycle as the write, through the bypass.
  - Via the array from the following cycle.
- No handshake back-pressure: `stall` and `flush` are level inputs, sampled each edge.
- When rs_addr == rt_addr == wb_addr, both ports receive `wb_data`.
- Stall refresh applies to every stalled cycle. With consecutive writes to the same held register, the last write wins.

## Test plan
- **Reset**: assert rst 2 cycles with `wb_en=1, wb_addr=5, wb_data=0xDEAD` → all `ex_*`=0; after release, read r5 → `ex_rs_data=0`.
- **Write/read**:
  - Write r3=0x12345678 in cycle 1; read rs=3 in cycle 3 → `ex_rs_data=0x12345678` one cycle later.
  - Write r0=0xFFFFFFFF, then read rt=0 → 0.
- **Bypass**: same cycle `wb_en=1, wb_addr=7, wb_data=0xA5A5A5A5`, `rs_addr=rt_addr=7` → next edge, `ex_rs_data=ex_rt_data=0xA5A5A5A5`.
- **Stall refresh**:
  - Latch rs=9 (old 0x1), then stall 3 cycles; write r9=0x2 in the 2nd stalled cycle → `ex_rs_data` becomes 0x2 and the other fields are unchanged.
  - Deassert stall with rs=9 → 0x2.
- **Flush vs stall**: `id_valid=1, stall=1, flush=1` → `ex_valid=0` and `ex_*` all 0; a concurrent write r4=0x55 is still performed (subsequent read r4 → 0x55).
- **Reset mid-stall**: hold latch with `ex_valid=1`, assert rst → all outputs 0 on the next edge and the in-flight write is dropped.
